// File: rtl/ad7864_multich_serializer.sv
// Reads NUM_CH words from the AD7864 parallel bus on each conversion-done edge and
// forwards them to the DSP McBSP as a single framed serial burst.
module ad7864_multich_serializer #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 12,
   parameter int PAD_W     = 16,
   parameter int SIGN_EXT  = 0,
   parameter int MSB_FIRST = 1,
   parameter int RD_LOW    = 2,
   parameter int RD_HIGH   = 2,
   parameter int SCLK_DIV  = 2
) (
   input  logic              clkin,
   input  logic              rst_bar,
   input  logic              db_rdy,
   input  logic [DATA_W-1:0] db,
   input  logic              clr_ovr,
   output logic              cs_bar,
   output logic              rd_bar,
   output logic              sclk,
   output logic              fsync,
   output logic              sdata,
   output logic              busy,
   output logic              overrun
);

   localparam int TOT     = NUM_CH * PAD_W;
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BIT_W   = (TOT > 1) ? $clog2(TOT) : 1;
   localparam int CNT_MAX = (RD_LOW > RD_HIGH)
                            ? ((RD_LOW > 2*SCLK_DIV) ? RD_LOW : 2*SCLK_DIV)
                            : ((RD_HIGH > 2*SCLK_DIV) ? RD_HIGH : 2*SCLK_DIV);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] LOW_END  = CNT_W'(RD_LOW - 1);
   localparam logic [CNT_W-1:0] HIGH_END = CNT_W'(RD_HIGH - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] PER_END  = CNT_W'(2*SCLK_DIV - 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOT - 1);

   typedef enum logic [1:0] {IDLE, READ, SYNC, SHIFT} state_t;

   state_t             state;
   logic               db_rdy_q;
   logic               rd_high;
   logic [CH_W-1:0]    ch;
   logic [CNT_W-1:0]   cnt;
   logic [BIT_W-1:0]   bit_cnt;
   logic [PAD_W-1:0]   slot_buf [NUM_CH];
   logic [TOT-1:0]     shreg;
   logic [TOT-1:0]     flat;
   logic               rdy_edge;

   assign rdy_edge = db_rdy & ~db_rdy_q;

   function automatic logic [PAD_W-1:0] pad_word(input logic [DATA_W-1:0] d);
      logic [PAD_W-1:0] r;
      r = (SIGN_EXT != 0) ? {PAD_W{d[DATA_W-1]}} : '0;
      r[DATA_W-1:0] = d;
      return r;
   endfunction

   function automatic logic head_bit(input logic [TOT-1:0] v);
      return (MSB_FIRST != 0) ? v[TOT-1] : v[0];
   endfunction

   function automatic logic [TOT-1:0] advance(input logic [TOT-1:0] v);
      return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
   endfunction

   // Frame image laid out so that the first bit to send always sits at the shift-out end.
   always_comb begin
      flat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (MSB_FIRST != 0) flat[(NUM_CH-1-i)*PAD_W +: PAD_W] = slot_buf[i];
         else                flat[i*PAD_W +: PAD_W]            = slot_buf[i];
      end
   end

   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         state    <= IDLE;
         db_rdy_q <= 1'b1;
         rd_high  <= 1'b0;
         ch       <= '0;
         cnt      <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         cs_bar   <= 1'b1;
         rd_bar   <= 1'b1;
         sclk     <= 1'b0;
         fsync    <= 1'b0;
         sdata    <= 1'b0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) slot_buf[i] <= '0;
      end else begin
         db_rdy_q <= db_rdy;
         if (rdy_edge && busy) overrun <= 1'b1;
         else if (clr_ovr)     overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (rdy_edge) begin
                  cs_bar  <= 1'b0;
                  rd_bar  <= 1'b0;
                  busy    <= 1'b1;
                  ch      <= '0;
                  cnt     <= '0;
                  rd_high <= 1'b0;
                  state   <= READ;
               end
            end
            READ: begin
               if (!rd_high) begin
                  if (cnt == LOW_END) begin
                     slot_buf[ch] <= pad_word(db);
                     rd_bar       <= 1'b1;
                     cnt          <= '0;
                     // Last channel skips the trailing high phase and releases the bus.
                     if (ch == LAST_CH) begin
                        cs_bar <= 1'b1;
                        fsync  <= 1'b1;
                        sclk   <= 1'b0;
                        state  <= SYNC;
                     end else begin
                        rd_high <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  if (cnt == HIGH_END) begin
                     rd_bar  <= 1'b0;
                     rd_high <= 1'b0;
                     ch      <= ch + 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            SYNC: begin
               if (cnt == PER_END) begin
                  fsync   <= 1'b0;
                  sclk    <= 1'b0;
                  sdata   <= head_bit(flat);
                  shreg   <= advance(flat);
                  bit_cnt <= '0;
                  cnt     <= '0;
                  state   <= SHIFT;
               end else begin
                  if (cnt == HALF_END) sclk <= 1'b1;
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == PER_END) begin
                  sclk <= 1'b0;
                  cnt  <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     sdata <= 1'b0;
                     busy  <= 1'b0;
                     ch    <= '0;
                     state <= IDLE;
                  end else begin
                     sdata   <= head_bit(shreg);
                     shreg   <= advance(shreg);
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  if (cnt == HALF_END) sclk <= 1'b1;
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad7864_multich_serializer.sv
// Scoreboard bench: three serializer instances share the ADC bus model; a monitor
// rebuilds serial slots and compares them against queued expected words.
module tb_ad7864_multich_serializer;

   typedef struct packed {
      logic [1:0]  dut;
      logic [15:0] word;
   } exp_t;

   logic        clkin = 1'b0;
   logic        rst_bar = 1'b0;
   logic        clr_ovr = 1'b0;
   logic [11:0] db = 12'h000;
   logic [2:0]  rdy_v = 3'b000;
   logic [2:0]  cs_v, rd_v, sclk_v, fsync_v, sdata_v, busy_v, ovr_v;

   int errors = 0;
   int checks = 0;

   exp_t        exp_q[$];
   logic [11:0] rd_vals[$];

   int PADW [3] = '{16, 12, 16};
   int MSBF [3] = '{1, 1, 0};
   int SDIV [3] = '{2, 1, 1};

   int          nb [3];
   logic [15:0] acc [3];
   int          busy_cnt [3];
   int          busy_len [3];
   int          fs_cnt [3];
   logic        first_pending [3];
   logic        first_bit [3];
   logic [2:0]  sclk_q = 3'b000;
   logic [2:0]  sdata_q = 3'b000;
   logic [2:0]  busy_q = 3'b000;
   int          rd_low = 0;
   int          rd_falls = 0;
   logic        rd0_q = 1'b1;
   logic        rd_any_q = 1'b1;

   always #5 clkin = ~clkin;

   ad7864_multich_serializer u_dut0 (
      .clkin(clkin), .rst_bar(rst_bar), .db_rdy(rdy_v[0]), .db(db), .clr_ovr(clr_ovr),
      .cs_bar(cs_v[0]), .rd_bar(rd_v[0]), .sclk(sclk_v[0]), .fsync(fsync_v[0]),
      .sdata(sdata_v[0]), .busy(busy_v[0]), .overrun(ovr_v[0]));

   ad7864_multich_serializer #(.NUM_CH(1), .PAD_W(12), .SCLK_DIV(1)) u_dut1 (
      .clkin(clkin), .rst_bar(rst_bar), .db_rdy(rdy_v[1]), .db(db), .clr_ovr(clr_ovr),
      .cs_bar(cs_v[1]), .rd_bar(rd_v[1]), .sclk(sclk_v[1]), .fsync(fsync_v[1]),
      .sdata(sdata_v[1]), .busy(busy_v[1]), .overrun(ovr_v[1]));

   ad7864_multich_serializer #(.NUM_CH(2), .SIGN_EXT(1), .MSB_FIRST(0), .SCLK_DIV(1)) u_dut2 (
      .clkin(clkin), .rst_bar(rst_bar), .db_rdy(rdy_v[2]), .db(db), .clr_ovr(clr_ovr),
      .cs_bar(cs_v[2]), .rd_bar(rd_v[2]), .sclk(sclk_v[2]), .fsync(fsync_v[2]),
      .sdata(sdata_v[2]), .busy(busy_v[2]), .overrun(ovr_v[2]));

   task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut%0d: got %0h, want %0h", name, k, act, exp);
      end
   endtask

   // ADC model: next queued word appears on the bus when any read strobe falls,
   // junk appears once the strobe rises again.
   always @(negedge clkin) begin
      logic rd_any;
      rd_any = &rd_v;
      if (rd_any_q && !rd_any) db = (rd_vals.size() > 0) ? rd_vals.pop_front() : 12'h5A5;
      else if (!rd_any_q && rd_any) db = 12'h5A5;
      rd_any_q = rd_any;
   end

   // Monitor: rebuilds slots from sclk rises, measures busy/fsync/rd_bar widths.
   always @(negedge clkin) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_bar) begin
            nb[k] = 0; acc[k] = '0; busy_cnt[k] = 0; fs_cnt[k] = 0;
            first_pending[k] = 1'b0;
            sclk_q[k] = 1'b0; sdata_q[k] = 1'b0; busy_q[k] = 1'b0;
         end else begin
            if (busy_v[k]) busy_cnt[k]++;
            else if (busy_q[k]) begin
               busy_len[k] = busy_cnt[k];
               busy_cnt[k] = 0;
            end
            if (fsync_v[k]) begin
               fs_cnt[k]++;
               first_pending[k] = 1'b1;
            end else if (fs_cnt[k] != 0) begin
               checkOutput("fsync_len", k, fs_cnt[k], 2*SDIV[k]);
               fs_cnt[k] = 0;
            end
            if (sclk_v[k] && !sclk_q[k] && !fsync_v[k]) begin
               checkOutput("bit_stable", k, {31'b0, sdata_v[k]}, {31'b0, sdata_q[k]});
               if (first_pending[k]) begin
                  first_bit[k] = sdata_v[k];
                  first_pending[k] = 1'b0;
               end
               if (MSBF[k] != 0) acc[k] = {acc[k][14:0], sdata_v[k]};
               else              acc[k][nb[k]] = sdata_v[k];
               nb[k]++;
               if (nb[k] == PADW[k]) begin
                  logic [15:0] word;
                  exp_t e;
                  word = acc[k] & 16'((32'd1 << PADW[k]) - 1);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL slot_unexpected dut%0d: got %0h, want none", k, word);
                  end else begin
                     e = exp_q.pop_front();
                     checkOutput("slot_dut", k, k, {30'b0, e.dut});
                     checkOutput("slot_word", k, {16'b0, word}, {16'b0, e.word});
                  end
                  nb[k] = 0;
                  acc[k] = '0;
               end
            end
            sclk_q[k] = sclk_v[k];
            sdata_q[k] = sdata_v[k];
            busy_q[k] = busy_v[k];
         end
      end
      if (!rst_bar) rd_low = 0;
      else if (!rd_v[0]) rd_low++;
      else if (rd_low != 0) begin
         checkOutput("rd_low_len", 0, rd_low, 2);
         rd_low = 0;
      end
      if (rd0_q && !rd_v[0]) rd_falls++;
      rd0_q = rd_v[0];
   end

   task automatic pulseRdy(input int k, input logic with_clr);
      @(posedge clkin); #2;
      rdy_v[k] = 1'b1;
      clr_ovr = with_clr;
      @(posedge clkin); #2;
      rdy_v[k] = 1'b0;
      clr_ovr = 1'b0;
   endtask

   task automatic applyStimulus(input int k, input int n,
                                input logic [11:0] a, b, c, d,
                                input logic [15:0] ea, eb, ec, ed);
      logic [11:0] v [4];
      logic [15:0] w [4];
      exp_t e;
      v = '{a, b, c, d};
      w = '{ea, eb, ec, ed};
      for (int i = 0; i < n; i++) begin
         rd_vals.push_back(v[i]);
         e.dut = 2'(k);
         e.word = w[i];
         exp_q.push_back(e);
      end
      pulseRdy(k, 1'b0);
      checkOutput("busy_start", k, {31'b0, busy_v[k]}, 1);
   endtask

   task automatic waitFrame(input int k, input int exp_busy);
      int n;
      n = 0;
      while (busy_v[k] !== 1'b0 && n < 2000) begin
         @(posedge clkin); #3;
         n++;
      end
      if (n >= 2000) begin
         checks++;
         errors++;
         $display("[TB] FAIL frame_timeout dut%0d: got busy after %0d cycles, want idle", k, n);
      end
      @(negedge clkin); #1;
      checkOutput("busy_len", k, busy_len[k], exp_busy);
      checkOutput("queue_empty", k, exp_q.size(), 0);
      checkOutput("cs_idle", k, {31'b0, cs_v[k]}, 1);
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst_cs_bar", 0, {31'b0, cs_v[0]}, 1);
      checkOutput("rst_rd_bar", 0, {31'b0, rd_v[0]}, 1);
      checkOutput("rst_sclk", 0, {31'b0, sclk_v[0]}, 0);
      checkOutput("rst_fsync", 0, {31'b0, fsync_v[0]}, 0);
      checkOutput("rst_sdata", 0, {31'b0, sdata_v[0]}, 0);
      checkOutput("rst_busy", 0, {31'b0, busy_v[0]}, 0);
      checkOutput("rst_overrun", 0, {31'b0, ovr_v[0]}, 0);
   endtask

   initial begin
      int falls0;
      #12;
      checkResetOutputs();
      #15 rst_bar = 1'b1;

      // Constant bus value, zero padding, MSB first
      falls0 = rd_falls;
      applyStimulus(0, 4, 12'hABC, 12'hABC, 12'hABC, 12'hABC,
                    16'h0ABC, 16'h0ABC, 16'h0ABC, 16'h0ABC);
      waitFrame(0, 274);
      checkOutput("rd_pulses", 0, rd_falls - falls0, 4);

      // Distinct words land in channel order
      applyStimulus(0, 4, 12'h001, 12'h002, 12'h003, 12'h004,
                    16'h0001, 16'h0002, 16'h0003, 16'h0004);
      waitFrame(0, 274);

      // Negative values without sign extension
      applyStimulus(0, 4, 12'h800, 12'h7FF, 12'hFFF, 12'h000,
                    16'h0800, 16'h07FF, 16'h0FFF, 16'h0000);
      waitFrame(0, 274);

      // Sign extension with LSB-first ordering
      applyStimulus(2, 2, 12'h001, 12'h800, 12'h000, 12'h000,
                    16'h0001, 16'hF800, 16'h0000, 16'h0000);
      waitFrame(2, 72);
      checkOutput("lsb_first_bit", 2, {31'b0, first_bit[2]}, 1);

      // Overrun set, clear, set-wins-over-clear, frame untouched
      applyStimulus(0, 4, 12'h111, 12'h222, 12'h333, 12'h444,
                    16'h0111, 16'h0222, 16'h0333, 16'h0444);
      repeat (97) @(posedge clkin);
      pulseRdy(0, 1'b0);
      checkOutput("ovr_set", 0, {31'b0, ovr_v[0]}, 1);
      repeat (20) @(posedge clkin);
      #2 clr_ovr = 1'b1;
      @(posedge clkin); #2 clr_ovr = 1'b0;
      checkOutput("ovr_clr_midframe", 0, {31'b0, ovr_v[0]}, 0);
      repeat (20) @(posedge clkin);
      pulseRdy(0, 1'b1);
      checkOutput("ovr_set_wins", 0, {31'b0, ovr_v[0]}, 1);
      waitFrame(0, 274);
      checkOutput("ovr_sticky", 0, {31'b0, ovr_v[0]}, 1);
      #2 clr_ovr = 1'b1;
      @(posedge clkin); #2 clr_ovr = 1'b0;
      checkOutput("ovr_clr_alone", 0, {31'b0, ovr_v[0]}, 0);

      // Asynchronous reset mid-SHIFT, then a clean frame
      applyStimulus(0, 4, 12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0,
                    16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0);
      repeat (150) @(posedge clkin);
      #2 rst_bar = 1'b0;
      #1 checkResetOutputs();
      exp_q.delete();
      rd_vals.delete();
      #24 rst_bar = 1'b1;
      applyStimulus(0, 4, 12'h123, 12'h456, 12'h789, 12'hABC,
                    16'h0123, 16'h0456, 16'h0789, 16'h0ABC);
      waitFrame(0, 274);

      // Single channel, unpadded slot, fastest sclk
      applyStimulus(1, 1, 12'h5C3, 12'h000, 12'h000, 12'h000,
                    16'h05C3, 16'h0000, 16'h0000, 16'h0000);
      waitFrame(1, 28);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
